servant_ram_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the single-port servant RAM between the CPU bus (master 0) and a secondary requester such as a UART boot loader or DMA (master 1). Grants are round-robin and held until the RAM acks. A watchdog terminates hung cycles with an error strobe. Sits between the masters and the RAM's i_wb_*/o_wb_* port.

---
 rtl/servant_ram_arbiter.sv | 144 ++++++++++++++
 tb/tb_servant_ram_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/servant_ram_arbiter.sv
// servant_ram_arbiter
// Two-master Wishbone arbiter in front of the single-port servant RAM.
// Master 0 is normally the CPU, master 1 a boot loader or DMA engine.
// Grants are round-robin and are held until the RAM acks. A watchdog ends
// a hung transfer with a one-cycle error strobe.
//
// Ports:
//   i_wb_clk, i_wb_rst_n   clock, asynchronous active-low reset
//   i_mX_adr/dat/sel/we/cyc   master X request (word address, data, byte enables)
//   o_mX_rdt/ack/err          master X read data, acknowledge, timeout error
//   o_s_adr/dat/sel/we/cyc    RAM request, driven from the granted master
//   i_s_rdt/ack               RAM read data and acknowledge
//   o_grant                   one-hot current grant (bit0 = m0), 00 when idle
module servant_ram_arbiter #(
  parameter int aw      = 10,
  parameter int TIMEOUT = 15
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic [aw-3:0] i_m0_adr,
  input  logic [31:0]   i_m0_dat,
  input  logic [3:0]    i_m0_sel,
  input  logic          i_m0_we,
  input  logic          i_m0_cyc,
  output logic [31:0]   o_m0_rdt,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  input  logic [aw-3:0] i_m1_adr,
  input  logic [31:0]   i_m1_dat,
  input  logic [3:0]    i_m1_sel,
  input  logic          i_m1_we,
  input  logic          i_m1_cyc,
  output logic [31:0]   o_m1_rdt,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic [aw-3:0] o_s_adr,
  output logic [31:0]   o_s_dat,
  output logic [3:0]    o_s_sel,
  output logic          o_s_we,
  output logic          o_s_cyc,
  input  logic [31:0]   i_s_rdt,
  input  logic          i_s_ack,
  output logic [1:0]    o_grant
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  // 1 = master 1 was served last, so master 0 wins the next tie
  logic       last_q, last_d;
  logic [7:0] wdog_q, wdog_d;

  logic busy;
  logic g_cyc;
  logic timeout;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      wdog_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    busy    = (state_q == BUSY);
    g_cyc   = grant_q[1] ? i_m1_cyc : i_m0_cyc;
    // An ack in the same cycle takes priority over the timeout, and a
    // dropped cyc is an abort rather than a timeout.
    timeout = busy && g_cyc && !i_s_ack && (wdog_q == TIMEOUT_CNT);

    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = wdog_q;

    case (state_q)
      IDLE: begin
        if (i_m0_cyc || i_m1_cyc) begin
          state_d = BUSY;
          wdog_d  = 8'd0;
          if (i_m0_cyc && i_m1_cyc) grant_d = last_q ? 2'b01 : 2'b10;
          else                      grant_d = i_m0_cyc ? 2'b01 : 2'b10;
        end
      end
      BUSY: begin
        // Every way out of BUSY passes through one IDLE cycle so the RAM's
        // self-clearing ack toggle sees cyc low before the next grant.
        if (i_s_ack || timeout || !g_cyc) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = grant_q[1];
          wdog_d  = 8'd0;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_comb begin
    o_s_adr = '0;
    o_s_dat = 32'd0;
    o_s_sel = 4'd0;
    o_s_we  = 1'b0;
    o_s_cyc = 1'b0;
    if (busy) begin
      if (grant_q[1]) begin
        o_s_adr = i_m1_adr;
        o_s_dat = i_m1_dat;
        o_s_sel = i_m1_sel;
        o_s_we  = i_m1_we;
      end else begin
        o_s_adr = i_m0_adr;
        o_s_dat = i_m0_dat;
        o_s_sel = i_m0_sel;
        o_s_we  = i_m0_we;
      end
      o_s_cyc = g_cyc;
    end
  end

  assign o_m0_rdt = i_s_rdt;
  assign o_m1_rdt = i_s_rdt;
  assign o_m0_ack = busy & grant_q[0] & i_s_ack;
  assign o_m1_ack = busy & grant_q[1] & i_s_ack;
  assign o_m0_err = timeout & grant_q[0];
  assign o_m1_err = timeout & grant_q[1];
  assign o_grant  = grant_q;

endmodule

// File: tb/tb_servant_ram_arbiter.sv
module tb_servant_ram_arbiter;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-3:0] m0_adr = '0, m1_adr = '0;
  logic [31:0]   m0_dat = 0, m1_dat = 0;
  logic [3:0]    m0_sel = 0, m1_sel = 0;
  logic          m0_we = 0, m1_we = 0, m0_cyc = 0, m1_cyc = 0;
  logic [31:0]   m0_rdt, m1_rdt;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic [AW-3:0] s_adr;
  logic [31:0]   s_dat;
  logic [3:0]    s_sel;
  logic          s_we, s_cyc;
  logic [31:0]   ram_rdt = 0;
  logic          ram_ack = 0;
  logic          ram_nack = 0;
  logic [1:0]    grant;
  logic [31:0]   mem [0:255];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  servant_ram_arbiter #(.aw(AW), .TIMEOUT(15)) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n),
    .i_m0_adr(m0_adr), .i_m0_dat(m0_dat), .i_m0_sel(m0_sel), .i_m0_we(m0_we), .i_m0_cyc(m0_cyc),
    .o_m0_rdt(m0_rdt), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we), .i_m1_cyc(m1_cyc),
    .o_m1_rdt(m1_rdt), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel), .o_s_we(s_we), .o_s_cyc(s_cyc),
    .i_s_rdt(ram_rdt), .i_s_ack(ram_ack), .o_grant(grant)
  );

  // Servant-style RAM: registered read, ack toggles while cyc is held
  always @(posedge clk) begin
    ram_ack <= s_cyc & ~ram_ack & ~ram_nack;
    ram_rdt <= mem[s_adr];
    if (s_cyc && s_we && !ram_ack) begin
      for (int b = 0; b < 4; b++)
        if (s_sel[b]) mem[s_adr][b*8 +: 8] <= s_dat[b*8 +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic cyc, input logic we, input logic [7:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    if (m) begin
      m1_cyc = cyc; m1_we = we; m1_adr = adr; m1_sel = sel; m1_dat = dat;
    end else begin
      m0_cyc = cyc; m0_we = we; m0_adr = adr; m0_sel = sel; m0_dat = dat;
    end
  endtask

  typedef struct {
    logic        m;
    logic        we;
    logic [7:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp_rdt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[5] = 32'hDEADBEEF;
    mem[3] = 32'h11223344;

    vecs[0] = '{1'b0, 1'b0, 8'd5, 4'b1111, 32'd0,          32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 8'd3, 4'b0100, 32'h00AB0000,   32'd0};
    vecs[2] = '{1'b0, 1'b0, 8'd3, 4'b1111, 32'd0,          32'h11AB3344};
    vecs[3] = '{1'b1, 1'b0, 8'd5, 4'b1111, 32'd0,          32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 8'd7, 4'b1111, 32'hCAFEF00D,   32'd0};
    vecs[5] = '{1'b1, 1'b0, 8'd7, 4'b1111, 32'd0,          32'hCAFEF00D};
    vecs[6] = '{1'b0, 1'b1, 8'd7, 4'b0001, 32'h000000AA,   32'd0};
    vecs[7] = '{1'b0, 1'b0, 8'd7, 4'b1111, 32'd0,          32'hCAFEF0AA};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_cyc", 32'(s_cyc), 32'd0);
    chk("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
    chk("rst_s_bus", 32'({s_we, s_sel, s_adr}), 32'd0);
    $display("[TB] reset state checked");
    rst_n = 1'b1;

    // Simultaneous requests: m0 first after reset, then strict alternation
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'd5, 4'hF, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 8'd3, 4'hF, 32'd0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("rr_grant", 32'(grant), (t % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_s_cyc", 32'(s_cyc), 32'd1);
      @(negedge clk);
      chk("rr_ack", 32'({m1_ack, m0_ack}), (t % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_rdt", m0_rdt, (t % 2 == 0) ? 32'hDEADBEEF : 32'h11223344);
      @(negedge clk);
      chk("rr_idle_grant", 32'(grant), 32'd0);
      chk("rr_idle_s_cyc", 32'(s_cyc), 32'd0);
      $display("[TB] round-robin transfer %0d grant checked", t);
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0, 4'h0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 4'h0, 32'd0);
    @(negedge clk);

    // Table of single-master transfers
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].m, 1'b1, vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat);
      @(negedge clk);
      chk("v_grant", 32'(grant), vecs[i].m ? 32'd2 : 32'd1);
      chk("v_s_adr", 32'(s_adr), 32'(vecs[i].adr));
      chk("v_s_we", 32'(s_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk("v_s_dat", s_dat, vecs[i].dat);
        chk("v_s_sel", 32'(s_sel), 32'(vecs[i].sel));
      end
      chk("v_noack_early", 32'({m1_ack, m0_ack}), 32'd0);
      @(negedge clk);
      chk("v_ack", 32'({m1_ack, m0_ack}), vecs[i].m ? 32'd2 : 32'd1);
      if (!vecs[i].we)
        chk("v_rdt", vecs[i].m ? m1_rdt : m0_rdt, vecs[i].exp_rdt);
      drive(vecs[i].m, 1'b0, 1'b0, 8'd0, 4'h0, 32'd0);
      @(negedge clk);
      chk("v_idle_s_cyc", 32'(s_cyc), 32'd0);
      chk("v_idle_grant", 32'(grant), 32'd0);
      $display("[TB] vector %0d m%0d we=%0d adr=%0d done", i, vecs[i].m, vecs[i].we, vecs[i].adr);
    end

    // Timeout: RAM never acks m1; m0 waits behind it and wins afterwards
    ram_nack = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'd9, 4'hF, 32'd0);
    @(negedge clk);
    chk("to_grant", 32'(grant), 32'd2);
    drive(1'b0, 1'b1, 1'b0, 8'd5, 4'hF, 32'd0);
    for (int k = 1; k < 15; k++) begin
      @(negedge clk);
      chk("to_early_err", 32'({m1_err, m0_err, m1_ack, m0_ack}), 32'd0);
    end
    @(negedge clk);
    chk("to_err", 32'({m1_err, m0_err}), 32'd2);
    chk("to_no_ack", 32'({m1_ack, m0_ack}), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 4'h0, 32'd0);
    ram_nack = 1'b0;
    @(negedge clk);
    chk("to_idle_grant", 32'(grant), 32'd0);
    chk("to_err_cleared", 32'({m1_err, m0_err}), 32'd0);
    @(negedge clk);
    chk("to_m0_grant", 32'(grant), 32'd1);
    @(negedge clk);
    chk("to_m0_ack", 32'(m0_ack), 32'd1);
    chk("to_m0_rdt", m0_rdt, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 4'h0, 32'd0);
    @(negedge clk);
    $display("[TB] timeout sequence done");

    // Abort: m0 drops cyc before the ack
    drive(1'b0, 1'b1, 1'b0, 8'd5, 4'hF, 32'd0);
    @(negedge clk);
    chk("ab_grant", 32'(grant), 32'd1);
    chk("ab_s_cyc_hi", 32'(s_cyc), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 8'd5, 4'hF, 32'd0);
    #1;
    chk("ab_s_cyc_fall", 32'(s_cyc), 32'd0);
    @(negedge clk);
    chk("ab_grant_idle", 32'(grant), 32'd0);
    chk("ab_no_ack_err", 32'({m1_err, m0_err, m1_ack, m0_ack}), 32'd0);
    @(negedge clk);
    $display("[TB] abort sequence done");

    // Asynchronous reset during BUSY, then m0 wins the first tie
    drive(1'b1, 1'b1, 1'b0, 8'd3, 4'hF, 32'd0);
    @(negedge clk);
    chk("ar_grant_busy", 32'(grant), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("ar_grant", 32'(grant), 32'd0);
    chk("ar_s_cyc", 32'(s_cyc), 32'd0);
    chk("ar_acks", 32'({m1_err, m0_err, m1_ack, m0_ack}), 32'd0);
    @(negedge clk);
    chk("ar_held", 32'({grant, s_cyc, m1_ack}), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'd5, 4'hF, 32'd0);
    @(negedge clk);
    chk("ar_tie_m0", 32'(grant), 32'd1);
    @(negedge clk);
    chk("ar_m0_ack", 32'({m1_ack, m0_ack}), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 8'd0, 4'h0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 4'h0, 32'd0);
    @(negedge clk);
    $display("[TB] async reset sequence done");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
